time_keeper: RTL and testbench
==============================

# time_keeper

Timekeeping and time-setting core of the digital clock. Runs on the 1 kHz system clock and derives an exact 1 s tick internally. Maintains a 24-hour hh:mm:ss count as six BCD digits, and handles button-driven time setting. Its digits and blink mask feed the display/flicker stage directly; its hourly pulse feeds the beep timer.

## Interface
- `TICKS_PER_SEC`, default 1000: clk_1khz cycles per second.
- `DEBOUNCE_TICKS`, default 20: cycles a button level must be stable before it is accepted.

Ports:
- `clk_1khz`  in  1  sole clock; all logic on the rising edge.
- `switch_clr`  in  1  reset, asynchronous, active-low.
- `switch_setting`  in  1  level; 1 = setting mode.
- `button_1`  in  1  raw push-button, field select, active-high.
- `button_2`  in  1  raw push-button, increment selected field, active-high.
- `display_1` … `display_6`  out  4 each  BCD digits: hour tens, hour ones, min tens, min ones, sec tens, sec ones.
- `flicker_mask`  out  6 (`[0:5]`)  bit i = 1 blinks display_(i+1).
- `sec_tick`  out  1  one-cycle pulse per elapsed second while running.
- `chime_req`  out  1  one-cycle pulse on each hour rollover.

## Operation
- Reset (`switch_clr`=0) forces the following: time 00:00:00, state RUN, prescaler 0, all outputs 0, synchronizers and debouncers cleared.
- **Input conditioning**
  - `button_1`, `button_2` and `switch_setting` each pass through a 2-flop synchronizer.
  - Each button then has a debouncer. The debounced level changes only after the synced level has differed from it for `DEBOUNCE_TICKS` consecutive cycles.
  - The debounced rising edge gives a one-cycle event, sel_ev or inc_ev.
  - `switch_setting` is used after synchronization only; it is not debounced.
- **Prescaler**
  - Counts 0..`TICKS_PER_SEC`-1 in RUN only.
  - At `TICKS_PER_SEC`-1 it wraps to 0 and asserts `sec_tick`.
  - Held at 0 in any SET state.
- **Time counting on sec_tick**
  - Seconds ones 9→0 carries into tens; tens 5→0 carries into minutes.
  - Minutes carry the same way into hours.
  - Hours count 00..23, and 23:59:59 → 00:00:00.
  - Digits never leave BCD range.
- **chime_req** asserts in the same cycle as a tick where mm:ss goes 59:59 → 00:00. It never asserts from setting actions.
- **FSM states**: RUN, SET_H, SET_M, SET_S.
  - RUN → SET_H when synced setting = 1.
  - From any SET state, synced setting = 0 → RUN. The prescaler restarts from 0.
  - sel_ev steps SET_H → SET_M → SET_S → SET_H.
  - sel_ev and inc_ev in RUN are ignored.
- **inc_ev in SET states**
  - SET_H: hours +1, wrapping 23 → 00.
  - SET_M: minutes +1, wrapping 59 → 00. No carry into hours.
  - SET_S: seconds cleared to 00.
- **Simultaneous events**: sel_ev and inc_ev in the same cycle apply sel_ev only; inc_ev is dropped.
- **flicker_mask**
  - RUN: 000000.
  - SET_H: 110000.
  - SET_M: 001100.
  - SET_S: 000011.
  - Bit 0 corresponds to display_1.

## Timing
- All outputs are registered.
- Digits update on the clock edge where sec_tick is high. The new value is visible the following cycle, together with the sec_tick and chime_req pulses.
- Running period is exactly `TICKS_PER_SEC` cycles between sec_tick pulses.
- The first tick after reset, or after leaving setting, comes `TICKS_PER_SEC` cycles after the prescaler starts.
- Button press latency: 2 (sync) + `DEBOUNCE_TICKS` + 1 cycles to the event. The field updates 1 cycle later.
- A held button produces exactly one event. A release shorter than `DEBOUNCE_TICKS` produces no new event.
- Setting-switch latency: 2 cycles to state change, plus 1 cycle to flicker_mask.
- Reset asserted mid-operation clears everything asynchronously. Counting resumes on the first edge after release.

## Test plan
- **Reset and count**: release reset, run 3000 cycles → display = 0,0,0,0,0,3 and exactly 3 `sec_tick` pulses, 1000 cycles apart.
- **Hour rollover**:
  - Set 00:59:58 via the buttons, then run 2000 cycles → 01:00:00.
  - `chime_req` pulses once, on the second tick.
  - From 23:59:59, one tick → 00:00:00 with chime_req.
- **Setting FSM**:
  - setting=1 → mask 110000.
  - 25 inc presses from hour 00 → hour 01.
  - sel → mask 001100; 60 inc presses → minutes unchanged.
  - sel → mask 000011; inc → seconds 00.
  - sel → mask 110000.
- **Debounce**:
  - A 10-cycle glitch on button_2 in SET_H → no change.
  - A 500-cycle press → exactly +1 hour.
  - A bounce (5 toggles within 15 cycles, then held) → exactly +1.
- **Simultaneous**: both buttons rise in the same cycle while in SET_H → state SET_M, hours unchanged.
- **Reset mid-setting**: in SET_M at 12:34:56, pulse `switch_clr` low for 1 cycle with setting held at 0 → 00:00:00, mask 000000, RUN, next tick 1000 cycles later.

Source files
------------

// File: rtl/time_keeper.sv
// time_keeper: 24-hour hh:mm:ss timekeeping core with button-driven setting.
//
// Runs on the 1 kHz system clock, derives a 1 s tick with an internal
// prescaler, keeps six BCD digits and lets the user set hours/minutes and
// clear seconds while the setting switch is on.
//
// Ports:
//   clk_1khz        1 kHz system clock, rising edge
//   switch_clr      asynchronous active-low reset
//   switch_setting  level, 1 = setting mode (synchronized, not debounced)
//   button_1        raw push-button, field select
//   button_2        raw push-button, increment selected field
//   display_1..6    BCD digits: hour tens/ones, min tens/ones, sec tens/ones
//   flicker_mask    [0:5], bit i blinks display_(i+1)
//   sec_tick        one-cycle pulse per elapsed second while running
//   chime_req       one-cycle pulse on each hour rollover
module time_keeper #(
  parameter int TICKS_PER_SEC  = 1000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk_1khz,
  input  logic       switch_clr,
  input  logic       switch_setting,
  input  logic       button_1,
  input  logic       button_2,
  output logic [3:0] display_1,
  output logic [3:0] display_2,
  output logic [3:0] display_3,
  output logic [3:0] display_4,
  output logic [3:0] display_5,
  output logic [3:0] display_6,
  output logic [0:5] flicker_mask,
  output logic       sec_tick,
  output logic       chime_req
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] SET_H = 2'd1;
  localparam logic [1:0] SET_M = 2'd2;
  localparam logic [1:0] SET_S = 2'd3;

  // Two-digit BCD increment modulo 60; bit 8 is the carry out of 59 -> 00.
  function automatic logic [8:0] inc_60(input logic [7:0] v);
    logic [8:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) begin
        r = {1'b1, 4'd0, 4'd0};
      end else begin
        r = {1'b0, v[7:4] + 4'd1, 4'd0};
      end
    end else begin
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Two-digit BCD increment modulo 24 (23 -> 00).
  function automatic logic [7:0] inc_24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Blink pattern for each state; leftmost literal bit is display_1.
  function automatic logic [0:5] mask_of(input logic [1:0] st);
    logic [0:5] r;
    case (st)
      SET_H:   r = 6'b110000;
      SET_M:   r = 6'b001100;
      SET_S:   r = 6'b000011;
      default: r = 6'b000000;
    endcase
    return r;
  endfunction

  logic                  set_s1_r, set_s2_r;
  logic [1:0]            btn_s1_r, btn_s2_r;
  logic [1:0]            deb_r, ev_r;
  logic [1:0][DW-1:0]    deb_cnt_r;
  logic [1:0]            state_r, state_nxt_s;
  logic [PW-1:0]         presc_r, presc_nxt_s;
  logic [7:0]            hour_r, min_r, sec_r;
  logic [7:0]            hour_nxt_s, min_nxt_s, sec_nxt_s;
  logic [8:0]            sec_inc_s, min_inc_s;
  logic                  tick_s, chime_s, tick_r, chime_r;
  logic [0:5]            mask_r;
  logic                  sel_ev_s, inc_ev_s;

  assign sel_ev_s = ev_r[0];
  assign inc_ev_s = ev_r[1];

  // Two-flop synchronizers for the setting switch and both buttons.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      set_s1_r <= 1'b0;
      set_s2_r <= 1'b0;
      btn_s1_r <= 2'b00;
      btn_s2_r <= 2'b00;
    end else begin
      set_s1_r <= switch_setting;
      set_s2_r <= set_s1_r;
      btn_s1_r <= {button_2, button_1};
      btn_s2_r <= btn_s1_r;
    end
  end

  // Debouncers: accept a new level after DEBOUNCE_TICKS consecutive
  // disagreeing samples; the accepted rising edge is the one-cycle event.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      deb_r     <= 2'b00;
      ev_r      <= 2'b00;
      deb_cnt_r <= '{default: DW'(0)};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s2_r[i] != deb_r[i]) begin
          if (deb_cnt_r[i] == DW'(DEBOUNCE_TICKS - 1)) begin
            deb_r[i]     <= btn_s2_r[i];
            deb_cnt_r[i] <= DW'(0);
            ev_r[i]      <= btn_s2_r[i];
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
            ev_r[i]      <= 1'b0;
          end
        end else begin
          deb_cnt_r[i] <= DW'(0);
          ev_r[i]      <= 1'b0;
        end
      end
    end
  end

  // Next-state logic: mode FSM, prescaler, setting actions and second tick.
  always_comb begin
    state_nxt_s = state_r;
    presc_nxt_s = presc_r;
    hour_nxt_s  = hour_r;
    min_nxt_s   = min_r;
    sec_nxt_s   = sec_r;
    tick_s      = 1'b0;
    chime_s     = 1'b0;
    sec_inc_s   = inc_60(sec_r);
    min_inc_s   = inc_60(min_r);
    case (state_r)
      RUN: begin
        if (presc_r == PW'(TICKS_PER_SEC - 1)) begin
          presc_nxt_s = PW'(0);
          tick_s      = 1'b1;
        end else begin
          presc_nxt_s = presc_r + PW'(1);
        end
        if (set_s2_r) begin
          state_nxt_s = SET_H;
        end else begin
          state_nxt_s = RUN;
        end
      end
      SET_H, SET_M, SET_S: begin
        presc_nxt_s = PW'(0);
        if (!set_s2_r) begin
          state_nxt_s = RUN;
        end else if (sel_ev_s) begin
          // select wins over a simultaneous increment
          state_nxt_s = (state_r == SET_S) ? SET_H : state_r + 2'd1;
        end else if (inc_ev_s) begin
          case (state_r)
            SET_H:   hour_nxt_s = inc_24(hour_r);
            SET_M:   min_nxt_s  = min_inc_s[7:0];
            default: sec_nxt_s  = 8'h00;
          endcase
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = RUN;
        presc_nxt_s = PW'(0);
      end
    endcase
    // Ticks only occur in RUN, so they never collide with setting actions.
    if (tick_s) begin
      sec_nxt_s = sec_inc_s[7:0];
      if (sec_inc_s[8]) begin
        min_nxt_s = min_inc_s[7:0];
        if (min_inc_s[8]) begin
          hour_nxt_s = inc_24(hour_r);
          chime_s    = 1'b1;
        end else begin
          hour_nxt_s = hour_r;
        end
      end else begin
        min_nxt_s = min_r;
      end
    end else begin
      chime_s = 1'b0;
    end
  end

  // Core state registers and registered outputs.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      state_r <= RUN;
      presc_r <= PW'(0);
      hour_r  <= 8'h00;
      min_r   <= 8'h00;
      sec_r   <= 8'h00;
      tick_r  <= 1'b0;
      chime_r <= 1'b0;
      mask_r  <= 6'b000000;
    end else begin
      state_r <= state_nxt_s;
      presc_r <= presc_nxt_s;
      hour_r  <= hour_nxt_s;
      min_r   <= min_nxt_s;
      sec_r   <= sec_nxt_s;
      tick_r  <= tick_s;
      chime_r <= chime_s;
      mask_r  <= mask_of(state_r);
    end
  end

  assign display_1    = hour_r[7:4];
  assign display_2    = hour_r[3:0];
  assign display_3    = min_r[7:4];
  assign display_4    = min_r[3:0];
  assign display_5    = sec_r[7:4];
  assign display_6    = sec_r[3:0];
  assign flicker_mask = mask_r;
  assign sec_tick     = tick_r;
  assign chime_req    = chime_r;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed plus randomized bench for time_keeper.
// The reference model keeps the time of day as seconds since midnight and
// the mode as a small integer; digits and blink masks are derived from those.
module tb_time_keeper;

  localparam int T = 1000;
  localparam int D = 20;

  logic       clk_1khz = 1'b0;
  logic       switch_clr = 1'b0;
  logic       switch_setting = 1'b0;
  logic       button_1 = 1'b0;
  logic       button_2 = 1'b0;
  logic [3:0] display_1, display_2, display_3, display_4, display_5, display_6;
  logic [0:5] flicker_mask;
  logic       sec_tick, chime_req;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int tick_cnt = 0;
  int chime_cnt = 0;
  int chime_alone = 0;
  int ticks_q[$];

  // reference model: time of day in seconds, mode 0=RUN 1=H 2=M 3=S
  int tod = 0;
  int mode = 0;

  time_keeper #(.TICKS_PER_SEC(T), .DEBOUNCE_TICKS(D)) dut (
    .clk_1khz      (clk_1khz),
    .switch_clr    (switch_clr),
    .switch_setting(switch_setting),
    .button_1      (button_1),
    .button_2      (button_2),
    .display_1     (display_1),
    .display_2     (display_2),
    .display_3     (display_3),
    .display_4     (display_4),
    .display_5     (display_5),
    .display_6     (display_6),
    .flicker_mask  (flicker_mask),
    .sec_tick      (sec_tick),
    .chime_req     (chime_req)
  );

  always #5 clk_1khz = ~clk_1khz;

  // pulse monitor: samples 1 time unit after each rising edge
  always begin
    @(posedge clk_1khz);
    cyc = cyc + 1;
    #1;
    if (switch_clr) begin
      if (sec_tick) begin
        tick_cnt = tick_cnt + 1;
        ticks_q.push_back(cyc);
      end
      if (chime_req) begin
        chime_cnt = chime_cnt + 1;
        if (!sec_tick) chime_alone = chime_alone + 1;
      end
    end
  end

  function automatic logic [23:0] digits_of(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [5:0] mask_of_mode(input int md);
    case (md)
      1:       return 6'b110000;
      2:       return 6'b001100;
      3:       return 6'b000011;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk_1khz);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag);
    chk(tag, {8'd0, display_1, display_2, display_3, display_4, display_5, display_6},
        {8'd0, digits_of(tod)});
  endtask

  task automatic check_mask(input string tag);
    chk(tag, {26'd0, flicker_mask}, {26'd0, mask_of_mode(mode)});
  endtask

  task automatic model_inc();
    int h, m, s;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
    case (mode)
      1:       h = (h + 1) % 24;
      2:       m = (m + 1) % 60;
      3:       s = 0;
      default: ;
    endcase
    tod = h * 3600 + m * 60 + s;
  endtask

  // which: 0 = select, 1 = increment, 2 = both together
  task automatic press(input int which, input int hold);
    if (which != 1) button_1 = 1'b1;
    if (which != 0) button_2 = 1'b1;
    step(hold);
    button_1 = 1'b0;
    button_2 = 1'b0;
    step(32);
    if (mode != 0) begin
      if (which != 1) mode = (mode == 3) ? 1 : mode + 1;
      else model_inc();
    end
  endtask

  task automatic glitch(input int which, input int len);
    if (which == 0) button_1 = 1'b1;
    else button_2 = 1'b1;
    step(len);
    button_1 = 1'b0;
    button_2 = 1'b0;
    step(32);
  endtask

  task automatic enter_setting();
    switch_setting = 1'b1;
    step(6);
    mode = 1;
  endtask

  task automatic run_ticks(input int k);
    int n0, lim;
    n0 = tick_cnt;
    lim = 0;
    while (tick_cnt < n0 + k && lim < (k + 1) * T + 10) begin
      step(1);
      lim++;
    end
    chk("tick_wait", tick_cnt - n0, k);
    tod = (tod + k) % 86400;
  endtask

  // leave setting and confirm the prescaler restarted from zero
  task automatic leave_setting();
    int d;
    switch_setting = 1'b0;
    d = cyc;
    mode = 0;
    run_ticks(1);
    chk("first_tick_lat", {31'd0, (ticks_q[$] - d) inside {[T + 2 : T + 4]}}, 32'd1);
  endtask

  initial begin
    int c0, c, n, r;

    // reset state
    step(3);
    chk("reset_outs", {display_1, display_2, display_3, display_4, display_5, display_6,
                       flicker_mask, sec_tick, chime_req}, 32'd0);

    // reset and count
    switch_clr = 1'b1;
    c0 = cyc;
    step(3 * T);
    tod = 3;
    check_time("count3");
    chk("tick_cnt3", tick_cnt, 3);
    chk("chime_none", chime_cnt, 0);
    chk("tickq_size", ticks_q.size(), 3);
    if (ticks_q.size() >= 3) begin
      chk("first_tick", ticks_q[0] - c0, T);
      chk("period1", ticks_q[1] - ticks_q[0], T);
      chk("period2", ticks_q[2] - ticks_q[1], T);
    end

    // setting FSM
    enter_setting();
    check_mask("mask_h");
    step(1500);
    check_time("frozen_in_set");
    repeat (25) press(1, 30);
    check_time("hour_25");
    press(0, 30);
    check_mask("mask_m");
    repeat (60) press(1, 30);
    check_time("min_60");
    press(0, 30);
    check_mask("mask_s");
    press(1, 30);
    check_time("sec_clear");
    press(0, 30);
    check_mask("mask_wrap");

    // debounce
    glitch(1, 10);
    check_time("glitch10");
    press(1, 500);
    check_time("hold500");
    for (int i = 0; i < 5; i++) begin
      button_2 = ~button_2;
      step(3);
    end
    press(1, 40);
    check_time("bounce");

    // simultaneous press: select only
    press(2, 30);
    check_mask("simul_mask");
    check_time("simul_time");

    // randomized setting actions
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       press(0, $urandom_range(25, 60));
        1:       press(1, $urandom_range(25, 60));
        2:       glitch($urandom_range(0, 1), $urandom_range(2, 15));
        default: press(2, $urandom_range(25, 60));
      endcase
      check_time("rand_time");
      check_mask("rand_mask");
    end

    // running: buttons ignored
    leave_setting();
    check_mask("mask_run");
    press(1, 30);
    press(0, 30);
    run_ticks(2);
    check_time("run_ignore");
    chk("run_period", ticks_q[$] - ticks_q[$-1], T);

    // hour and day rollover
    enter_setting();
    n = (23 - tod / 3600 + 24) % 24;
    repeat (n) press(1, 25);
    press(0, 25);
    n = (59 - (tod / 60) % 60 + 60) % 60;
    repeat (n) press(1, 25);
    press(0, 25);
    press(1, 25);
    press(0, 25);
    check_time("set_235900");
    leave_setting();
    run_ticks(57);
    check_time("t235958");
    c = chime_cnt;
    run_ticks(1);
    check_time("t235959");
    chk("no_chime_59", chime_cnt - c, 0);
    run_ticks(1);
    check_time("t000000");
    chk("chime_once", chime_cnt - c, 1);
    chk("chime_with_tick", chime_alone, 0);

    // reset mid-setting
    enter_setting();
    press(0, 30);
    press(1, 30);
    press(1, 30);
    check_mask("pre_clr_mask");
    switch_setting = 1'b0;
    switch_clr = 1'b0;
    #1;
    mode = 0;
    tod = 0;
    check_time("clr_time");
    check_mask("clr_mask");
    @(negedge clk_1khz);
    switch_clr = 1'b1;
    c0 = cyc;
    run_ticks(1);
    check_time("after_clr");
    chk("after_clr_lat", ticks_q[$] - c0, T);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
